// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// State encoding, port ids and the tie-break helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  // Winner for a request pair; ties use
  // round-robin or data-port priority.
  function automatic logic arb_pick(
    input logic r0,
    input logic r1,
    input logic last,
    input logic rr
  );
    logic w;
    w = PORT_IF;
    if (r0 && r1)
      w = rr ? ~last : PORT_DM;
    else if (r1)
      w = PORT_DM;
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Request-path mux bank: bitwise 2:1 muxes
// steered by the registered port select.
module mux2_1 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

module mux2_1_bus #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    mux2_1 u_mux (
      .i_a  (i_a[g]),
      .i_b  (i_b[g]),
      .i_sel(i_sel),
      .o_y  (o_y[g])
    );
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one single-ported
// memory: fetch on port 0, data on port 1.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_sel;
  logic              w_sel_nxt;
  logic              r_last_gnt;
  logic [DATA_W-1:0] r_rdata;
  logic              w_busy;
  logic              w_done;
  logic              w_ack;

  // State and port select; select only moves
  // when leaving IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sel   <= PORT_IF;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Next state and winner selection.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    unique case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_sel_nxt   = arb_pick(req0, req1,
                                 r_last_gnt, RR_EN);
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (mem_ack)
          w_state_nxt = DONE;
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ack = (r_state == WAIT) && mem_ack;

  // Capture read data and remember the winner
  // once memory acknowledges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata    <= '0;
      r_last_gnt <= PORT_DM;
    end else if (w_ack) begin
      if (!mem_we)
        r_rdata <= mem_rdata;
      r_last_gnt <= r_sel;
    end
  end

  assign w_busy = (r_state != IDLE);
  assign w_done = (r_state == DONE);

  assign gnt0   = w_busy && (r_sel == PORT_IF);
  assign gnt1   = w_busy && (r_sel == PORT_DM);
  assign done0  = w_done && (r_sel == PORT_IF);
  assign done1  = w_done && (r_sel == PORT_DM);
  assign mem_en = (r_state == ISSUE);
  assign sel    = r_sel;
  assign rdata  = r_rdata;

  mux2_1_bus #(.WIDTH(ADDR_W)) u_mux_addr (
    .i_a  (addr0),
    .i_b  (addr1),
    .i_sel(r_sel),
    .o_y  (mem_addr)
  );

  mux2_1_bus #(.WIDTH(DATA_W)) u_mux_wdata (
    .i_a  (wdata0),
    .i_b  (wdata1),
    .i_sel(r_sel),
    .o_y  (mem_wdata)
  );

  mux2_1_bus #(.WIDTH(1)) u_mux_we (
    .i_a  (we0),
    .i_b  (we1),
    .i_sel(r_sel),
    .o_y  (mem_we)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin and fixed-priority
// arbiters side by side on shared stimulus.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic        gnt0_a, gnt1_a, done0_a, done1_a;
  logic        sel_a, en_a, mwe_a;
  logic [63:0] rd_a, maddr_a, mwd_a;
  logic        gnt0_b, gnt1_b, done0_b, done1_b;
  logic        sel_b, en_b, mwe_b;
  logic [63:0] rd_b, maddr_b, mwd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR_EN(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0_a), .gnt1(gnt1_a),
    .done0(done0_a), .done1(done1_a),
    .rdata(rd_a), .sel(sel_a),
    .mem_en(en_a), .mem_we(mwe_a),
    .mem_addr(maddr_a), .mem_wdata(mwd_a),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.RR_EN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0_b), .gnt1(gnt1_b),
    .done0(done0_b), .done1(done1_b),
    .rdata(rd_b), .sel(sel_b),
    .mem_en(en_b), .mem_we(mwe_b),
    .mem_addr(maddr_b), .mem_wdata(mwd_b),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [63:0] a0, a1, wd0, wd1;
    int          dly;
    logic [63:0] mrd;
    logic        drop;
    logic        sel_rr, sel_fp;
    logic [63:0] exp_rd;
    int          lat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Mutual exclusion of grants, every cycle.
  always @(negedge clk) begin
    checks++;
    if ((gnt0_a && gnt1_a) || (gnt0_b && gnt1_b)) begin
      errors++;
      $display("FAIL gnt_excl: both grants high at %0t",
               $time);
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    logic [63:0] e_addr, e_wd, b_addr;
    logic        e_we;
    req0 = v.r0; req1 = v.r1;
    we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1;
    wdata0 = v.wd0; wdata1 = v.wd1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (!en_a)
        chk("done_pulse", {63'd0, done0_a | done1_a}, 64'd0);
    end while (!en_a && n < 10);
    chk("en_seen", {63'd0, en_a}, 64'd1);
    if (!en_a) begin
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    chk("latency", 64'(n), 64'(v.lat));
    e_addr = v.sel_rr ? v.a1 : v.a0;
    e_wd   = v.sel_rr ? v.wd1 : v.wd0;
    e_we   = v.sel_rr ? v.w1 : v.w0;
    b_addr = v.sel_fp ? v.a1 : v.a0;
    chk("sel_a", {63'd0, sel_a}, {63'd0, v.sel_rr});
    chk("gnt0_a", {63'd0, gnt0_a}, {63'd0, ~v.sel_rr});
    chk("gnt1_a", {63'd0, gnt1_a}, {63'd0, v.sel_rr});
    chk("maddr_a", maddr_a, e_addr);
    chk("mwe_a", {63'd0, mwe_a}, {63'd0, e_we});
    chk("mwd_a", mwd_a, e_wd);
    chk("sel_b", {63'd0, sel_b}, {63'd0, v.sel_fp});
    chk("en_b", {63'd0, en_b}, 64'd1);
    chk("maddr_b", maddr_b, b_addr);
    for (int i = 0; i < v.dly; i++) begin
      @(posedge clk); #1;
      chk("en_off", {63'd0, en_a}, 64'd0);
      if (i == 0 && v.drop) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    mem_rdata = v.mrd;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("done0_a", {63'd0, done0_a}, {63'd0, ~v.sel_rr});
    chk("done1_a", {63'd0, done1_a}, {63'd0, v.sel_rr});
    chk("rdata_a", rd_a, v.exp_rd);
    chk("done1_b", {63'd0, done1_b}, {63'd0, v.sel_fp});
    chk("rdata_b", rd_b, v.exp_rd);
  endtask

  task automatic chk_quiet(input string nm);
    chk(nm, {59'd0, gnt0_a, gnt1_a, done0_a,
             done1_a, en_a}, 64'd0);
  endtask

  initial begin
    vec_t v;
    int n;
    tbl[0] = '{1, 0, 0, 0, 64'h40, 64'h0, 64'h0, 64'h0,
               3, 64'hDEAD, 0, 0, 0, 64'hDEAD, 1};
    tbl[1] = '{0, 1, 0, 1, 64'h0, 64'h80, 64'h0, 64'h1234,
               1, 64'hBEEF, 0, 1, 1, 64'hDEAD, 2};
    tbl[2] = '{1, 1, 0, 0, 64'h100, 64'h200, 64'hA0, 64'hB1,
               1, 64'h1111, 0, 0, 1, 64'h1111, 2};
    tbl[3] = '{1, 1, 0, 0, 64'h100, 64'h200, 64'hA0, 64'hB1,
               2, 64'h2222, 0, 1, 1, 64'h2222, 2};
    tbl[4] = '{1, 1, 0, 0, 64'h100, 64'h200, 64'hA0, 64'hB1,
               1, 64'h3333, 0, 0, 1, 64'h3333, 2};
    tbl[5] = '{1, 1, 0, 0, 64'h100, 64'h200, 64'hA0, 64'hB1,
               1, 64'h4444, 0, 1, 1, 64'h4444, 2};
    tbl[6] = '{1, 1, 0, 0, 64'h100, 64'h200, 64'hA0, 64'hB1,
               1, 64'h5555, 0, 0, 1, 64'h5555, 2};

    reset_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset_out");
    chk("reset_sel", {63'd0, sel_a}, 64'd0);
    chk("reset_rdata", rd_a, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Abort a transaction in WAIT with reset.
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!en_a && n < 10);
    chk("rst_en_seen", {63'd0, en_a}, 64'd1);
    @(posedge clk); #1;
    chk("rst_in_wait", {63'd0, gnt0_a}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_sel", {63'd0, sel_a}, 64'd0);
    chk("async_rdata", rd_a, 64'd0);
    req0 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    mem_rdata = 64'h7777;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk_quiet("late_ack");
    @(posedge clk); #1;
    chk_quiet("late_ack2");
    chk("late_rdata", rd_a, 64'd0);

    // First tie after reset goes to port 0.
    v = '{1, 1, 0, 0, 64'h300, 64'h400, 64'h1, 64'h2,
          1, 64'h6666, 0, 0, 1, 64'h6666, 1};
    run_vec(v);

    // Requester drops during WAIT.
    v = '{1, 0, 0, 0, 64'h500, 64'h0, 64'h0, 64'h0,
          2, 64'h5A5A, 1, 0, 0, 64'h5A5A, 2};
    run_vec(v);

    // Spurious ack while IDLE.
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk_quiet("spur_ack");
    @(posedge clk); #1;
    chk_quiet("spur_ack2");
    chk("spur_rdata", rd_a, 64'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
